// File: rtl/ddr_phy_dm_gearbox.sv
// ddr_phy_dm_gearbox
//   Write data-mask gearbox for the DDR PHY clk100m domain. Packs per-lane
//   2-phase DM (p0/p1) into OSER8 8-slot words, applies a per-lane slot delay
//   that carries delayed slots into the following word, and produces the
//   matching OSER8 TX (tristate) words from a pre/active/post drive window.
//
//   Optional feature macro: DDR_PHY_DM_OE_EN
//     defined   : drive-window FSM, busy, cfg_load deferred while busy
//     undefined : p_dm_oe tied 0 (always drive), busy tied 0,
//                 cfg_load always applies next cycle
//
// Ports
//   clk100m    in   PHY core clock, posedge
//   phy_rst_n  in   asynchronous active-low reset
//   wr_en      in   burst word valid
//   wdm        in   lane n {p1,p0} at [2n+1:2n]
//   cfg_shift  in   lane n slot delay at [3n+2:3n]
//   cfg_load   in   capture cfg_shift
//   p_dm       out  lane n OSER8 D7..D0 at [8n+7:8n], D0 serialized first
//   p_dm_oe    out  lane n OSER8 TX3..TX0, 0 = drive, 1 = Hi-Z
//   busy       out  drive window active
module ddr_phy_dm_gearbox #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned PRE_CYC   = 1,
    parameter int unsigned POST_CYC  = 1,
    parameter logic        DM_IDLE   = 1'b0,
    parameter logic [2:0]  SHIFT_RST = 3'd2
) (
    input  logic               clk100m,
    input  logic               phy_rst_n,
    input  logic               wr_en,
    input  logic [LANES*2-1:0] wdm,
    input  logic [LANES*3-1:0] cfg_shift,
    input  logic               cfg_load,
    output logic [LANES*8-1:0] p_dm,
    output logic [LANES*4-1:0] p_dm_oe,
    output logic               busy
);

    // One pipeline stage is always provided; with PRE_CYC=0 it is bypassed.
    localparam int unsigned DEPTH  = (PRE_CYC == 0) ? 1 : PRE_CYC;
    localparam logic [7:0]  IDLE_W = {8{DM_IDLE}};

    logic [LANES-1:0][7:0]             w_word;
    logic [LANES-1:0][7:0]             cur_w;
    logic [LANES-1:0][7:0]             prev_w;
    logic [LANES-1:0][7:0]             out_w;
    logic [DEPTH-1:0][LANES-1:0][7:0]  dly_w;
    logic [LANES-1:0][2:0]             shift_q;

    always_comb begin
        w_word = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            w_word[n] = wr_en ? {{4{wdm[2*n+1]}}, {4{wdm[2*n]}}} : IDLE_W;
        end
    end

    always_ff @(posedge clk100m or negedge phy_rst_n) begin
        if (!phy_rst_n) begin
            dly_w <= {DEPTH*LANES{IDLE_W}};
        end else begin
            dly_w[0] <= w_word;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                dly_w[i] <= dly_w[i-1];
            end
        end
    end

    // The final stage feeds the output register, which supplies the last cycle
    // of the PRE_CYC+1 latency.
    assign cur_w = (PRE_CYC == 0) ? w_word : dly_w[DEPTH-1];

    // Slot delay S: the top S slots of the previous word land in D(S-1)..D0,
    // so nothing is lost across a word boundary. S=0 shifts by 8 -> cur.
    always_comb begin
        out_w = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            out_w[n] = 8'({cur_w[n], prev_w[n]} >> (4'd8 - {1'b0, shift_q[n]}));
        end
    end

    always_ff @(posedge clk100m or negedge phy_rst_n) begin
        if (!phy_rst_n) begin
            prev_w <= {LANES{IDLE_W}};
            p_dm   <= {LANES{IDLE_W}};
        end else begin
            prev_w <= cur_w;
            p_dm   <= out_w;
        end
    end

`ifdef DDR_PHY_DM_OE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_ACTIVE, ST_POST} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DEPTH-1:0]      dly_v;
    logic                  cur_v;
    logic                  v_out;
    logic                  any_pend;
    logic [LANES-1:0][2:0] pend_q;
    logic                  pend_v;

    always_ff @(posedge clk100m or negedge phy_rst_n) begin
        if (!phy_rst_n) begin
            dly_v <= '0;
            v_out <= 1'b0;
        end else begin
            dly_v[0] <= wr_en;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                dly_v[i] <= dly_v[i-1];
            end
            v_out <= cur_v;
        end
    end

    assign cur_v = (PRE_CYC == 0) ? wr_en : dly_v[DEPTH-1];

    // ACTIVE is held while any word is still in flight (v_out covers the word
    // on p_dm whose delayed slots spill into the next cycle), so a new wr_en
    // landing inside ACTIVE never opens a Hi-Z gap.
    assign any_pend = wr_en | (|dly_v) | v_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_POST: begin
                if (wr_en) begin
                    if (PRE_CYC == 0) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_PRE;
                        cnt_d   = 2'(PRE_CYC - 1);
                    end
                end else if (state_q == ST_POST) begin
                    if (cnt_q == 2'd0) state_d = ST_IDLE;
                    else               cnt_d   = cnt_q - 2'd1;
                end
            end
            ST_PRE: begin
                if (cnt_q == 2'd0) state_d = ST_ACTIVE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            ST_ACTIVE: begin
                if (!any_pend) begin
                    if (POST_CYC == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_POST;
                        cnt_d   = 2'(POST_CYC - 1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk100m or negedge phy_rst_n) begin
        if (!phy_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            p_dm_oe <= '1;
            shift_q <= {LANES{SHIFT_RST}};
            pend_q  <= '0;
            pend_v  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d != ST_IDLE);
            p_dm_oe <= {LANES*4{state_d == ST_IDLE}};
            if (state_q == ST_IDLE) begin
                if (cfg_load) shift_q <= cfg_shift;
            end else if (state_d == ST_IDLE) begin
                // A load on the final busy cycle supersedes the pending value.
                if (cfg_load)    shift_q <= cfg_shift;
                else if (pend_v) shift_q <= pend_q;
                pend_v <= 1'b0;
            end else if (cfg_load) begin
                pend_q <= cfg_shift;
                pend_v <= 1'b1;
            end
        end
    end
`else
    assign p_dm_oe = '0;
    assign busy    = 1'b0;

    always_ff @(posedge clk100m or negedge phy_rst_n) begin
        if (!phy_rst_n) begin
            shift_q <= {LANES{SHIFT_RST}};
        end else if (cfg_load) begin
            shift_q <= cfg_shift;
        end
    end
`endif

endmodule
